// File: rtl/pwm_duty_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_duty_ctrl
// Brief    : Duty sequencer / over-current protection in front of the PWM
//            generator. Optional macro PWM_DUTY_CLAMP_EN clamps targets.
// Revision : 1.0  initial release
// ============================================================================
module pwm_duty_ctrl #(
  parameter logic [10:0] SLEW_STEP   = 11'h010,
  parameter int unsigned FAULT_LIMIT = 3,
  parameter logic [10:0] DUTY_IDLE   = 11'h400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [10:0] duty_tgt,
  input  logic        tgt_vld,
  output logic        tgt_rdy,
  input  logic        PWM_synch,
  input  logic        ovr_I,
  input  logic        ovr_I_blank,
  input  logic        clr_fault,
  output logic [10:0] duty,
  output logic        fault,
  output logic        running
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STOP  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [2:0]  c_fault_limit = FAULT_LIMIT[2:0];
  localparam logic [10:0] c_clamp_lo    = 11'h080;
  localparam logic [10:0] c_clamp_hi    = 11'h780;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [10:0] r_tgt;
  logic [10:0] w_tgt_in;
  logic [10:0] w_goal;
  logic [10:0] w_step;
  logic [11:0] w_up;
  logic [11:0] w_dn;
  logic [10:0] r_duty;
  logic        r_flag;
  logic [2:0]  r_fcnt;
  logic [2:0]  w_fcnt_inc;
  logic        w_qual;
  logic        w_faulted;
  logic        w_fault_trip;
  logic        w_enter_idle;

  // ---------------------------------------------------------------- target
`ifdef PWM_DUTY_CLAMP_EN
  // Keep a minimum on-time on both bridge legs beyond the dead-time.
  always_comb begin
    w_tgt_in = duty_tgt;
    if (duty_tgt < c_clamp_lo)
      w_tgt_in = c_clamp_lo;
    else if (duty_tgt > c_clamp_hi)
      w_tgt_in = c_clamp_hi;
  end
`else
  assign w_tgt_in = duty_tgt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_tgt <= DUTY_IDLE;
    else if (tgt_vld && tgt_rdy)
      r_tgt <= w_tgt_in;
  end

  // ------------------------------------------------------------- slew step
  assign w_goal = (r_state == S_RUN) ? r_tgt : DUTY_IDLE;
  assign w_up   = {1'b0, r_duty} + {1'b0, SLEW_STEP};
  assign w_dn   = {1'b0, r_duty} - {1'b0, SLEW_STEP};

  // A borrow out of the 12-bit subtract means the step went below zero.
  always_comb begin
    w_step = r_duty;
    if (r_duty < w_goal) begin
      if (w_up > {1'b0, w_goal})
        w_step = w_goal;
      else
        w_step = w_up[10:0];
    end else if (r_duty > w_goal) begin
      if (w_dn[11] || (w_dn < {1'b0, w_goal}))
        w_step = w_goal;
      else
        w_step = w_dn[10:0];
    end
  end

  // ------------------------------------------------- over-current counting
  assign w_qual       = ovr_I && !ovr_I_blank;
  assign w_faulted    = r_flag || w_qual;
  assign w_fcnt_inc   = (r_fcnt == 3'd7) ? 3'd7 : (r_fcnt + 3'd1);
  assign w_fault_trip = PWM_synch && w_faulted && (w_fcnt_inc >= c_fault_limit);

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (PWM_synch && en)
          w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!en)
          w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (PWM_synch) begin
          if (en)
            w_state_nxt = S_RUN;
          else if (w_step == DUTY_IDLE)
            w_state_nxt = S_IDLE;
        end
      end
      S_FAULT: begin
        if (clr_fault && !en)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_fault_trip && (r_state != S_FAULT))
      w_state_nxt = S_FAULT;
  end

  assign w_enter_idle = (w_state_nxt == S_IDLE) && (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag <= 1'b0;
      r_fcnt <= 3'd0;
    end else begin
      if (PWM_synch) begin
        r_flag <= 1'b0;
        r_fcnt <= w_faulted ? w_fcnt_inc : 3'd0;
      end else if (w_qual) begin
        r_flag <= 1'b1;
      end
      if (w_enter_idle)
        r_fcnt <= 3'd0;
    end
  end

  // ------------------------------------------------------------ duty reg
  // Fault entry parks the bridge immediately, not at the next boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_duty <= DUTY_IDLE;
    else if ((w_state_nxt == S_FAULT) || (r_state == S_FAULT) || (r_state == S_IDLE))
      r_duty <= DUTY_IDLE;
    else if (PWM_synch && ((r_state == S_RUN) || (r_state == S_STOP)))
      r_duty <= w_step;
  end

  assign duty    = r_duty;
  assign tgt_rdy = (r_state == S_RUN);
  assign running = (r_state == S_RUN);
  assign fault   = (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: doc/pwm_duty_ctrl.md
# pwm_duty_ctrl

Sequencer and protection controller in front of the 11-bit PWM generator. It accepts duty targets from the control loop, applies them only at PWM period boundaries, and limits the slew per period. It also ramps the bridge to and from the idle (50 %) duty on enable/disable. It counts unblanked over-current periods and forces a latched fault shutdown.

## Interface
- SLEW_STEP, 11'h010, maximum duty change applied per PWM period
- FAULT_LIMIT, 3, consecutive over-current periods that trigger shutdown (1..7)
- DUTY_IDLE, 11'h400, zero-average duty used in IDLE/STOP/FAULT
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  drive enable from system control
- duty_tgt  in  11  requested duty
- tgt_vld  in  1  duty_tgt valid
- tgt_rdy  out  1  target accepted this cycle when tgt_vld & tgt_rdy
- PWM_synch  in  1  one-cycle pulse at PWM counter == 0 (period start)
- ovr_I  in  1  raw over-current comparator
- ovr_I_blank  in  1  blanking window from PWM generator
- clr_fault  in  1  fault clear request
- duty  out  11  registered duty to PWM generator
- fault  out  1  latched fault flag
- running  out  1  high in RUN state

## Operation
- States: IDLE, RUN, STOP, FAULT; reset → IDLE.
- Target register tgt (11 b): loaded on tgt_vld & tgt_rdy; tgt_rdy = (state == RUN). Latest accepted value wins; no queue. Reset value DUTY_IDLE.
- Effective goal: RUN → tgt; IDLE/STOP → DUTY_IDLE.
- Duty step, evaluated only on PWM_synch in RUN/STOP:
  - If duty < goal: duty ← min(duty + SLEW_STEP, goal).
  - If duty > goal: duty ← max(duty − SLEW_STEP, goal).
  - Arithmetic in 12 b, so no wrap at 0 or 11'h7FF.
- Transitions:
  - IDLE→RUN on PWM_synch with en=1.
  - RUN→STOP when en=0, on any cycle.
  - STOP→IDLE on PWM_synch when the step result equals DUTY_IDLE.
  - STOP→RUN on PWM_synch when en=1.
  - Any state except FAULT → FAULT when the fault counter reaches FAULT_LIMIT.
  - FAULT→IDLE on clr_fault & ~en; clr_fault with en=1 is ignored.
- Over-current qualification:
  - qual = ovr_I & ~ovr_I_blank.
  - A sticky period flag sets on qual.
  - On PWM_synch: if (flag | qual) then fcnt++ (3 b, saturating) else fcnt ← 0. The flag then clears.
  - fcnt clears on entry to IDLE.
- FAULT entry: duty ← DUTY_IDLE in the same clock edge, not at a boundary. fault=1 and stays set through FAULT. fault clears on the FAULT→IDLE edge.
- IDLE: duty held at DUTY_IDLE.

## Timing
- Reset values: duty=DUTY_IDLE, fault=0, running=0, tgt_rdy=0, tgt=DUTY_IDLE, fcnt=0.
- duty updates on the clk edge where PWM_synch=1, so the new value is visible while the PWM counter = 1.
- One PWM period = 2048 clk. A full 0→0x7FF excursion takes ceil(0x7FF/SLEW_STEP) periods.
- Target accepted in cycle N takes effect at the first PWM_synch after N. A target accepted in the same cycle as PWM_synch is not used until the next synch.
- en falling in RUN: running drops the next cycle and tgt_rdy drops with it. Ramping toward DUTY_IDLE continues at boundaries.
- Fault detection: shutdown occurs on the PWM_synch edge that closes the FAULT_LIMIT-th consecutive faulted period. qual in the synch cycle itself counts toward the closing period.
- Asynchronous reset mid-ramp or in FAULT returns all state to the reset values immediately.

## Configuration
- PWM_DUTY_CLAMP_EN defined:
  - Accepted duty_tgt is clamped to [11'h080, 11'h780] before loading tgt.
  - This guarantees both PWM outputs a minimum on-time beyond the 0x40 non-overlap.
- Undefined: duty_tgt is loaded unmodified across the full 0..11'h7FF range.

## Test plan
- Reset, en=1, target 11'h480 accepted: duty steps 0x400→0x410→…→0x480 on 8 successive PWM_synch pulses; running=1 after the first synch.
- In RUN at 0x480, present 0x7F0 then 0x100 back-to-back before a synch: only 0x100 is used, and duty steps down 0x470, 0x460, …
- en=0 at duty 0x480: STOP, ramping 0x470…0x400, then IDLE on the synch that reaches 0x400; tgt_rdy=0 throughout.
- ovr_I asserted only inside ovr_I_blank for 10 periods: no count, fault=0. Unblanked ovr_I in 3 consecutive periods: fault=1 and duty=0x400 on the third synch edge. A gap period before the third resets the count.
- In FAULT, clr_fault with en=1: no effect. clr_fault with en=0: IDLE, fault=0, and a new enable restarts from 0x400.
- With PWM_DUTY_CLAMP_EN, target 0x7FF: duty settles at 0x780; target 0x010: duty settles at 0x080. Without the macro, the same targets reach 0x7FF and 0x010.
